// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: Moore control FSM that steps a 16-bit multicycle
// datapath through fetch, decode, execute, memory and writeback states.
//
// Ports:
//   Clock, Reset     - clock; synchronous active-high reset to FETCH
//   Opcode[3:0]      - IR[15:12] from the registered instruction
//   Zero             - ALU zero flag (acted on by the datapath via PCWriteCond)
//   MemReady         - data memory completion, qualifies MEM_RD / MEM_WR
//   PCWrite, PCWriteCond, IRWrite, RegDst, ALUSrc, ALUOp[1:0], Shift,
//   MemRead, MemWrite, MemToReg, RegWrite - datapath control vocabulary
//   Retire           - one-cycle pulse on the last cycle of an instruction
//   Illegal          - high while parked in TRAP
//   State[3:0]       - current state code for debug
//
// Optional build macro SEQ_PERF_CNT_EN adds InstrCount[15:0] and
// CycleCount[15:0] performance counters.

module multicycle_sequencer #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        Shift,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        Retire,
    output logic        Illegal,
    output logic [3:0]  State
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0] InstrCount,
    output logic [15:0] CycleCount
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_SH  = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_WB_ALU   = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd15;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // The branch decision is made by the datapath gating PCWriteCond with
    // Zero, so the sequencer itself never needs the flag.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    4'b0000, 4'b0001:          state_d = S_EXEC_R;
                    4'b0010:                   state_d = S_EXEC_SH;
                    4'b1001, 4'b1010, 4'b1011: state_d = S_EXEC_I;
                    4'b1100, 4'b1101:          state_d = S_MEM_ADDR;
                    4'b1111:                   state_d = S_BRANCH;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_SH:  state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_WB_ALU:   state_d = S_FETCH;
            S_MEM_ADDR: begin
                state_d = (Opcode == 4'b1100) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD:   state_d = MemReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = MemReady ? S_FETCH : S_MEM_WR;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            // Unused codes can only come from corruption; park in TRAP.
            default:    state_d = S_TRAP;
        endcase
    end

    // Everything, including State, reads as zero while Reset is high so a
    // reset landing mid-instruction cannot commit any write.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        ALUSrc      = 1'b0;
        ALUOp       = 2'b00;
        Shift       = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        Retire      = 1'b0;
        Illegal     = 1'b0;
        State       = 4'd0;
        if (!Reset) begin
            State = state_q;
            unique case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_EXEC_R: begin
                    ALUOp = 2'b10;
                end
                S_EXEC_SH: begin
                    Shift = 1'b1;
                    ALUOp = 2'b10;
                end
                S_EXEC_I: begin
                    ALUOp  = 2'b11;
                    ALUSrc = 1'b1;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    Retire   = 1'b1;
                    RegDst   = (Opcode == 4'b0000) ||
                               (Opcode == 4'b0001) ||
                               (Opcode == 4'b0010);
                    // Keep the shifter result on the writeback bus.
                    Shift    = (Opcode == 4'b0010);
                end
                S_MEM_ADDR: begin
                    ALUSrc = 1'b1;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    ALUSrc  = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                    Retire   = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    ALUSrc   = 1'b1;
                    // A store completes in the cycle memory accepts it.
                    Retire   = MemReady;
                end
                S_BRANCH: begin
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    Retire      = 1'b1;
                end
                S_TRAP: begin
                    Illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] instr_cnt_q;
    logic [15:0] instr_cnt_d;
    logic [15:0] cycle_cnt_q;
    logic [15:0] cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 16'd1;
        instr_cnt_d = instr_cnt_q + {15'd0, Retire};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cycle_cnt_q <= 16'd0;
            instr_cnt_q <= 16'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign InstrCount = instr_cnt_q;
    assign CycleCount = cycle_cnt_q;
`endif

endmodule
